// File: rtl/sram_port_arbiter.sv
// Round-robin bridge from NCH sram-like request channels onto one synchronous SRAM port,
// with kseg0/kseg1 address folding and a fixed-latency response return path.
module sram_port_arbiter #(
    parameter int NCH    = 2,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1,
    parameter int MAP_EN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        req_valid,
    output logic [NCH-1:0]        req_ready,
    input  logic [NCH*DW/8-1:0]   req_we,
    input  logic [NCH*AW-1:0]     req_addr,
    input  logic [NCH*DW-1:0]     req_wdata,
    output logic [NCH-1:0]        rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  rsp_uncached,
    output logic                  sram_en,
    output logic [DW/8-1:0]       sram_wen,
    output logic [AW-1:0]         sram_addr,
    output logic [DW-1:0]         sram_wdata,
    input  logic [DW-1:0]         sram_rdata
);
    localparam int BW = DW / 8;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CW-1:0] rr;
    logic          grant_any;
    logic [CW-1:0] grant_id;
    int            scan_idx;
    logic [AW-1:0] virt_addr;
    logic [2:0]    seg;
    logic          is_kseg;
    logic          is_kseg1;
    logic [DW-1:0] rdata_delayed;

    logic [RD_LAT-1:0]         pipe_valid;
    logic [RD_LAT-1:0]         pipe_write;
    logic [RD_LAT-1:0]         pipe_unc;
    logic [RD_LAT-1:0][CW-1:0] pipe_id;

    // Grants are suppressed while reset is held so every output reads zero during reset.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = 0;
        if (!reset) begin
            for (int k = 0; k < NCH; k++) begin
                scan_idx = (int'(rr) + k) % NCH;
                if (!grant_any && req_valid[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_id  = CW'(scan_idx);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        sram_en    = grant_any;
        sram_wen   = '0;
        sram_wdata = '0;
        virt_addr  = '0;
        if (grant_any) begin
            sram_wen   = req_we[int'(grant_id)*BW +: BW];
            sram_wdata = req_wdata[int'(grant_id)*DW +: DW];
            virt_addr  = req_addr[int'(grant_id)*AW +: AW];
        end
    end

    // kseg0 and kseg1 both fold onto the low 512 MB of physical space.
    assign seg       = virt_addr[AW-1 -: 3];
    assign is_kseg   = (seg == 3'b100) || (seg == 3'b101);
    assign is_kseg1  = (seg == 3'b101);
    assign sram_addr = ((MAP_EN != 0) && is_kseg) ? {3'b000, virt_addr[AW-4:0]} : virt_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr <= '0;
        end else if (grant_any) begin
            rr <= (int'(grant_id) == NCH - 1) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
            pipe_write <= '0;
            pipe_unc   <= '0;
            pipe_id    <= '0;
        end else begin
            pipe_valid[0] <= grant_any;
            pipe_write[0] <= |sram_wen;
            pipe_unc[0]   <= grant_any && is_kseg1;
            pipe_id[0]    <= grant_id;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_write[i] <= pipe_write[i-1];
                pipe_unc[i]   <= pipe_unc[i-1];
                pipe_id[i]    <= pipe_id[i-1];
            end
        end
    end

    // The SRAM already contributes one cycle, so only RD_LAT-1 extra stages are needed.
    if (RD_LAT == 1) begin : g_rdata_pass
        assign rdata_delayed = sram_rdata;
    end else begin : g_rdata_delay
        logic [RD_LAT-2:0][DW-1:0] rdata_pipe;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rdata_pipe <= '0;
            end else begin
                rdata_pipe[0] <= sram_rdata;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    rdata_pipe[i] <= rdata_pipe[i-1];
                end
            end
        end
        assign rdata_delayed = rdata_pipe[RD_LAT-2];
    end

    always_comb begin
        rsp_valid    = '0;
        rsp_rdata    = '0;
        rsp_uncached = 1'b0;
        if (pipe_valid[RD_LAT-1]) begin
            rsp_valid[pipe_id[RD_LAT-1]] = 1'b1;
            rsp_uncached                 = pipe_unc[RD_LAT-1];
            if (!pipe_write[RD_LAT-1]) begin
                rsp_rdata = rdata_delayed;
            end
        end
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Parametrised memory-side bridge between NCH sram-like CPU request channels (instruction, data, and later DMA or debug) and a single synchronous SRAM port. Each cycle it grants one channel round-robin and maps kseg0/kseg1 virtual addresses to physical addresses. It drives the SRAM and returns each read's data or each write's acknowledgement to the originating channel after a fixed RD_LAT cycles. It sits between the CPU core and the on-chip SRAM controller in the SoC top.

## Interface
- NCH, 2: number of request channels, 1..8
- AW, 32: address width, ≥ 29
- DW, 32: data width, multiple of 8
- RD_LAT, 1: request-to-response latency in cycles, 1..4
- MAP_EN, 1: 1 = kseg0/kseg1 address mapping on; 0 = addresses pass through unchanged

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NCH  per-channel request valid
- req_ready  out  NCH  one-hot grant, combinational
- req_we  in  NCH*DW/8  byte write enables; all zero = read
- req_addr  in  NCH*AW  virtual byte address
- req_wdata  in  NCH*DW  write data
- rsp_valid  out  NCH  one-hot response strobe
- rsp_rdata  out  DW  read data, qualified by rsp_valid
- rsp_uncached  out  1  response came from a kseg1 access
- sram_en  out  1  SRAM enable
- sram_wen  out  DW/8  SRAM byte write enables
- sram_addr  out  AW  physical address
- sram_wdata  out  DW  SRAM write data
- sram_rdata  in  DW  SRAM read data, valid one cycle after sram_en

## Operation
- Channel i uses slice i of each flattened bus (bits [i*W +: W]).
- Arbitration: round-robin pointer rr, reset 0. Grant goes to the first channel with req_valid set, searching rr, rr+1, … modulo NCH. On grant g, rr becomes (g+1) mod NCH. rr holds when nothing is granted.
- The granted channel's request drives sram_en=1, sram_wen, sram_wdata and the mapped sram_addr in the same cycle. With no grant, sram_en=0 and sram_wen=0.
- Mapping, with MAP_EN=1 and seg = addr[AW-1:AW-3]:
  - seg 3'b100 (kseg0) or 3'b101 (kseg1): top 3 bits forced to 000.
  - Any other seg: address unchanged.
  - With MAP_EN=0, all addresses pass through unchanged.
- Response pipeline: RD_LAT-deep shift register of {valid, channel id, uncached}. It is loaded on grant and shifts every cycle, with no backpressure; channels must accept responses unconditionally.
- Reads: rsp_rdata is sram_rdata delayed by RD_LAT-1 register stages. For RD_LAT=1 it is combinational passthrough.
- Writes: rsp_valid is asserted as an acknowledgement at the same latency, with rsp_rdata=0.
- Outside a valid response, rsp_rdata=0 and rsp_uncached=0.

## Timing
- Request accepted in cycle T (req_valid[g] & req_ready[g]). SRAM access occurs in cycle T. rsp_valid[g] is high in cycle T+RD_LAT, for exactly one cycle.
- Throughput: one request per cycle in aggregate, with back-to-back grants allowed.
- req_ready depends combinationally on req_valid and rr. A requester must hold valid, address, data and we stable until it sees ready.
- Simultaneous requests: exactly one is granted; the others see ready=0 and retry.
- A grant and a response in the same cycle are independent.
- Reset values: rr=0, pipeline valid bits 0. Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_uncached=0, sram_en=0, sram_wen=0.
- Reset asserted mid-operation clears the pipeline immediately. In-flight responses are dropped and are never delivered after reset deasserts.

## Test plan
- NCH=2, RD_LAT=1: ch0 reads 0x9FC0_0000 with sram_rdata=0x2408_0001 → sram_addr=0x1FC0_0000, sram_en=1 in cycle T; rsp_valid=2'b01, rsp_rdata=0x2408_0001, rsp_uncached=0 in cycle T+1.
- ch1 reads 0xBFAF_F000 → sram_addr=0x1FAF_F000; rsp_valid=2'b10 and rsp_uncached=1 in cycle T+1. With MAP_EN=0 the same request gives sram_addr=0xBFAF_F000.
- Both channels hold req_valid for 6 cycles → grants 0,1,0,1,0,1; responses follow in the same order, each one RD_LAT cycles behind its grant.
- ch1 writes we=4'b0011, addr 0x8000_0010, wdata 0xDEAD_BEEF → sram_wen=4'b0011, sram_addr=0x0000_0010, sram_wdata=0xDEAD_BEEF; rsp_valid[1] with rsp_rdata=0 in cycle T+1.
- RD_LAT=3, NCH=4: channels 3, 0, 2 issue single reads on consecutive cycles → rsp_valid is 1000, 0001, 0100 in cycles T+3..T+5, each carrying that cycle's delayed sram_rdata.
- RD_LAT=3: assert reset one cycle after two reads are granted → all outputs 0 immediately; after deassertion no rsp_valid appears and rr=0.
